// File: rtl/sdrc_lite_mcb_pkg.sv
// Shared sdrc_lite MCB definitions: burst/CAS encodings, limits and decode helpers.
package sdrc_lite_mcb_pkg;

  localparam int unsigned BL_MAX = 8;
  localparam int unsigned CL_MAX = 3;
  localparam int unsigned BEAT_W = 4;

  typedef enum logic [1:0] {
    BL_1 = 2'd0,
    BL_2 = 2'd1,
    BL_4 = 2'd2,
    BL_8 = 2'd3
  } bl_code_e;

  typedef enum logic [1:0] {
    CL_2 = 2'd2,
    CL_3 = 2'd3
  } cl_code_e;

  function automatic logic [BEAT_W-1:0] bl_beats(input logic [1:0] code);
    return BEAT_W'(1) << code;
  endfunction

  // Anything other than CL2 runs at CL3.
  function automatic logic [1:0] cl_cycles(input logic [1:0] code);
    return (code == CL_2) ? 2'd2 : 2'd3;
  endfunction

endpackage

// File: rtl/mcb_rd_pipe.sv
// Read-beat shift register: bit i set means d_dp_ie is due i cycles from now.
module mcb_rd_pipe
  import sdrc_lite_mcb_pkg::*;
#(
  parameter int unsigned DEPTH = CL_MAX + BL_MAX
) (
  input  logic              mcb_clk,
  input  logic              mcb_rst,
  input  logic              ld,
  input  logic [1:0]        cl,
  input  logic [BEAT_W-1:0] beats,
  output logic              d_dp_ie,
  output logic              mcb_rvld,
  output logic              late_c,
  output logic              pend_c
);

  logic [DEPTH-1:0] sr;
  logic [DEPTH-1:0] sr_nxt;
  logic [DEPTH-1:0] mask;

  // New burst lands CL cycles out, overlaid on beats still in flight.
  always_comb begin
    mask = '0;
    if (ld) begin
      mask = DEPTH'((DEPTH'(1) << beats) - DEPTH'(1)) << cl;
    end
    sr_nxt = (sr >> 1) | mask;
  end

  // A capture beat due one or more cycles after next cycle blocks a write issue.
  assign late_c  = |sr_nxt[DEPTH-1:1];
  assign pend_c  = |sr_nxt;
  assign d_dp_ie = sr[0];

  always_ff @(posedge mcb_clk) begin
    if (mcb_rst) begin
      sr       <= '0;
      mcb_rvld <= 1'b0;
    end else begin
      sr       <= sr_nxt;
      mcb_rvld <= sr[0];
    end
  end

endmodule

// File: rtl/mcb_dat_seq.sv
// Data-phase sequencer: write beat counter, read pipe and DQ turnaround permissions.
module mcb_dat_seq #(
  parameter int unsigned BL_MAX = sdrc_lite_mcb_pkg::BL_MAX,
  parameter int unsigned CL_MAX = sdrc_lite_mcb_pkg::CL_MAX
) (
  input  logic       mcb_clk,
  input  logic       mcb_rst,
  input  logic [1:0] cfg_cl,
  input  logic [1:0] cfg_bl,
  input  logic       c_wr_go,
  input  logic       c_rd_go,
  output logic       d_wr_ld,
  output logic       d_dp_oe,
  output logic       d_dp_ie,
  output logic       i_ready,
  output logic       mcb_rvld,
  output logic       d_wr_ok,
  output logic       d_rd_ok,
  output logic       d_busy,
  output logic       d_err
);

  import sdrc_lite_mcb_pkg::*;

  localparam int unsigned DEPTH = CL_MAX + BL_MAX;

  logic [BEAT_W-1:0] wr_cnt;
  logic [BEAT_W-1:0] cnt_nxt;
  logic [BEAT_W-1:0] beats_c;
  logic [1:0]        rd_cl_c;
  logic              acc_wr_c;
  logic              acc_rd_c;
  logic              bad_c;
  logic              late_c;
  logic              pend_c;

  // Issue arbitration; wr_cnt counts request cycles still owed after this one.
  always_comb begin
    beats_c  = bl_beats(cfg_bl);
    rd_cl_c  = cl_cycles(cfg_cl);
    acc_wr_c = c_wr_go & ~c_rd_go & d_wr_ok;
    acc_rd_c = c_rd_go & ~c_wr_go & d_rd_ok;
    bad_c    = (c_wr_go | c_rd_go) & ~acc_wr_c & ~acc_rd_c;
    cnt_nxt  = '0;
    if (acc_wr_c) begin
      cnt_nxt = beats_c - BEAT_W'(1);
    end else if (wr_cnt != '0) begin
      cnt_nxt = wr_cnt - BEAT_W'(1);
    end
  end

  // First request is flagged in the issue cycle so the host can start beat 0 immediately.
  assign i_ready = ~mcb_rst & (acc_wr_c | (wr_cnt != '0));

  mcb_rd_pipe #(
    .DEPTH (DEPTH)
  ) u_rd_pipe (
    .mcb_clk  (mcb_clk),
    .mcb_rst  (mcb_rst),
    .ld       (acc_rd_c),
    .cl       (rd_cl_c),
    .beats    (beats_c),
    .d_dp_ie  (d_dp_ie),
    .mcb_rvld (mcb_rvld),
    .late_c   (late_c),
    .pend_c   (pend_c)
  );

  always_ff @(posedge mcb_clk) begin
    if (mcb_rst) begin
      wr_cnt  <= '0;
      d_wr_ld <= 1'b0;
      d_dp_oe <= 1'b0;
      d_err   <= 1'b0;
      d_busy  <= 1'b0;
      d_wr_ok <= 1'b1;
      d_rd_ok <= 1'b1;
    end else begin
      wr_cnt  <= cnt_nxt;
      d_wr_ld <= i_ready;
      d_dp_oe <= d_wr_ld;
      d_err   <= bad_c;
      d_wr_ok <= ~late_c & (cnt_nxt == '0);
      d_rd_ok <= (cnt_nxt <= BEAT_W'(1));
      d_busy  <= (cnt_nxt != '0) | i_ready | d_wr_ld | pend_c | d_dp_ie;
    end
  end

endmodule
